cfg_loader: RTL
===============

// Module: cfg_loader
// PURPOSE
//  Configuration loader upstream of the CLB array. Deserializes a bit-serial
//  bitstream into CFG_W-bit CLB configuration words and drives the shared
//  bits bus plus a one-hot per-CLB write-enable, loading CLB 0..N_CLB-1 in order.
//  Completion is signalled with done_o; the fabric is not considered configured before that.
// PARAMETERS
//  N_CLB   4   number of CLBs on the config bus (>=1)
//  CFG_W   23  config word width: [22:19] route sel, [18] reg/comb sel, [17:16] pass sel, [15:0] LUT
// PORTS
//  clk_i        in   1          single clock, all logic on posedge
//  rst_i        in   1          synchronous reset, active-high
//  start_i      in   1          1-cycle pulse: begin a new configuration pass
//  cfg_valid_i  in   1          serial bit valid
//  cfg_data_i   in   1          serial config bit, MSB of each word first
//  cfg_ready_o  out  1          loader accepts a bit this cycle
//  bits_o       out  CFG_W      config word to CLB bits inputs (shared bus)
//  wr_en_o      out  N_CLB      one-hot write enable, bit k -> CLB k wr_en
//  busy_o       out  1          pass in progress (SHIFT or WRITE)
//  done_o       out  1          all N_CLB words written; held until next start_i or rst_i
// BEHAVIOUR
//  Reset: state=IDLE, bits_o=0, wr_en_o=0, cfg_ready_o=0, busy_o=0, done_o=0, counters=0.
//  Reset wins over every other input in the same cycle; reset mid-pass aborts with no further wr_en pulse.
//  States: IDLE, SHIFT, WRITE, DONE.
//   IDLE : start_i -> SHIFT (bit_cnt=0, word_cnt=0, done_o=0).
//   SHIFT: cfg_ready_o=1. A bit is accepted when cfg_valid_i&cfg_ready_o: shreg<={shreg[CFG_W-2:0],cfg_data_i}, bit_cnt++.
//          On acceptance of bit CFG_W-1 -> WRITE; the next-cycle bits_o = completed word.
//   WRITE: exactly one cycle. wr_en_o[word_cnt]=1, other bits 0. cfg_ready_o=0; input ignored.
//          bits_o stable this cycle and held unchanged until the next word completes
//          (CLB samples on the wr_en edge; hold gives one extra cycle of margin).
//          word_cnt++, bit_cnt=0; if word_cnt was N_CLB-1 -> DONE, else -> SHIFT.
//   DONE : done_o=1, busy_o=0, cfg_ready_o=0. start_i -> SHIFT (new pass, done_o cleared).
//  busy_o=1 in SHIFT and WRITE only.
//  Latency: last bit of a word accepted at edge t -> wr_en pulse in cycle t..t+1; next bit accepted no earlier than edge t+2.
//  Gaps: cfg_valid_i low in SHIFT stalls with no state change; no timeout.
//  start_i in SHIFT/WRITE: restart. Partial word discarded, word_cnt=0, any WRITE pulse in that cycle still completes.
//   Already-written CLBs are rewritten by the new pass.
//  start_i and cfg_valid_i in the same IDLE/DONE cycle: the bit is not accepted (ready low).
//  Counters: bit_cnt width $clog2(CFG_W), word_cnt width $clog2(N_CLB)+1; no wrap, the FSM terminates first.
//  wr_en_o never has more than one bit set; all zero outside WRITE.
// STRUCTURE
//  Package fpga_cfg_pkg: CFG_W, field localparams (LUT_LSB=0, LUT_W=16, PASS_LSB=16, REG_BIT=18, ROUTE_LSB=19),
//   cfg_state_e enum {IDLE,SHIFT,WRITE,DONE}; shared with CLB and future routing-block loaders.
//  Sub-module cfg_shift_reg (CFG_W): serial-in/parallel-out with load enable and sync clear.
//  Top holds the FSM, counters, one-hot decode, and the bits_o holding register.
// TESTING
//  1 Reset: rst_i held 2 cycles mid-SHIFT -> all outputs 0, IDLE; a later start_i begins cleanly at CLB 0.
//  2 N_CLB=2, stream 23'h035237 then 23'h365A37 with continuous valid -> wr_en_o=2'b01 with bits_o=035237,
//    then 2'b10 with bits_o=365A37; done_o=1 one cycle after the second pulse.
//  3 Same stream with random valid gaps -> identical words/pulse order; cfg_ready_o=0 in each WRITE cycle.
//  4 start_i after 10 bits of word 1 -> no wr_en pulse for the partial word; the full restream writes CLB 0 first.
//  5 CLB-integration: load 23'h035237 into a CLB model -> pass-through (down_o==up_i, right_o==left_i) after done_o.
//  6 Assertions: $onehot0(wr_en_o); bits_o stable while wr_en_o!=0 and for one cycle after; done_o&busy_o never both high.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared configuration definitions for the FPGA fabric loaders: the CLB
// config word layout and the loader state encoding.
package fpga_cfg_pkg;

    // CLB configuration word width and field positions.
    localparam int CFG_W     = 23;
    localparam int LUT_LSB   = 0;
    localparam int LUT_W     = 16;
    localparam int PASS_LSB  = 16;
    localparam int PASS_W    = 2;
    localparam int REG_BIT   = 18;
    localparam int ROUTE_LSB = 19;
    localparam int ROUTE_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } cfg_state_e;

    // Extract the pass-through select field from a CLB config word.
    function automatic logic [PASS_W-1:0] get_pass_sel(input logic [CFG_W-1:0] word);
        return word[PASS_LSB +: PASS_W];
    endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial-in/parallel-out deserializer. Only the first W-1 bits are stored;
// the word presented on o_word is completed by the bit currently on i_bit,
// so the owner can capture a full word on the same edge that accepts its
// last bit.
module cfg_shift_reg #(
    parameter int W = 23
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_bit,
    output logic [W-1:0] o_word
);

    logic [W-2:0] r_q;

    // Shift accepted bits in MSB-first; reset and clear both empty the register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= {(W-1){1'b0}};
        end else if (i_clr) begin
            r_q <= {(W-1){1'b0}};
        end else if (i_en) begin
            r_q <= {r_q[W-3:0], i_bit};
        end else begin
            r_q <= r_q;
        end
    end

    assign o_word = {r_q, i_bit};

endmodule

// File: rtl/cfg_loader.sv
// Configuration loader: deserializes a bit-serial stream into CFG_W-bit CLB
// config words and writes them to CLB 0..N_CLB-1 in order over a shared bits
// bus with a one-hot write enable.
module cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int N_CLB = 4,
    parameter int CFG_W = fpga_cfg_pkg::CFG_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             cfg_valid_i,
    input  logic             cfg_data_i,
    output logic             cfg_ready_o,
    output logic [CFG_W-1:0] bits_o,
    output logic [N_CLB-1:0] wr_en_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int BC_W = $clog2(CFG_W);
    localparam int WC_W = $clog2(N_CLB) + 1;

    cfg_state_e       r_state;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [WC_W-1:0]  r_word_cnt;
    logic [CFG_W-1:0] r_bits;
    logic [N_CLB-1:0] r_wr_en;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic [CFG_W-1:0] w_word;
    logic [N_CLB-1:0] w_dec;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_last_word;

    // A start pulse discards any partial word, so it also clears the deserializer.
    cfg_shift_reg #(.W(CFG_W)) u_shift (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_clr  (start_i),
        .i_en   (w_accept),
        .i_bit  (cfg_data_i),
        .o_word (w_word)
    );

    // Handshake and counter terminal conditions; a restart takes precedence over a bit.
    always_comb begin
        w_accept    = cfg_valid_i & r_ready & ~start_i;
        w_last_bit  = (r_bit_cnt == BC_W'(CFG_W - 1));
        w_last_word = (r_word_cnt == WC_W'(N_CLB - 1));
    end

    // One-hot decode of the word counter into the next write enable.
    always_comb begin
        w_dec = {N_CLB{1'b0}};
        for (int k = 0; k < N_CLB; k++) begin
            if (r_word_cnt == WC_W'(k)) begin
                w_dec[k] = 1'b1;
            end else begin
                w_dec[k] = 1'b0;
            end
        end
    end

    // Loader FSM with registered handshake, status, bits bus and write-enable outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_bit_cnt  <= {BC_W{1'b0}};
            r_word_cnt <= {WC_W{1'b0}};
            r_bits     <= {CFG_W{1'b0}};
            r_wr_en    <= {N_CLB{1'b0}};
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state    <= SHIFT;
                        r_bit_cnt  <= {BC_W{1'b0}};
                        r_word_cnt <= {WC_W{1'b0}};
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (start_i) begin
                        r_bit_cnt  <= {BC_W{1'b0}};
                        r_word_cnt <= {WC_W{1'b0}};
                    end else if (w_accept) begin
                        if (w_last_bit) begin
                            // Word complete: present it and pulse this CLB's enable next cycle.
                            r_state   <= WRITE;
                            r_bits    <= w_word;
                            r_wr_en   <= w_dec;
                            r_bit_cnt <= {BC_W{1'b0}};
                            r_ready   <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        end
                    end
                end
                WRITE: begin
                    // The pulse lasts exactly one cycle even if a restart arrives now.
                    r_wr_en   <= {N_CLB{1'b0}};
                    r_bit_cnt <= {BC_W{1'b0}};
                    if (start_i) begin
                        r_state    <= SHIFT;
                        r_word_cnt <= {WC_W{1'b0}};
                        r_ready    <= 1'b1;
                    end else if (w_last_word) begin
                        r_state    <= DONE;
                        r_word_cnt <= r_word_cnt + WC_W'(1);
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state    <= SHIFT;
                        r_word_cnt <= r_word_cnt + WC_W'(1);
                        r_ready    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_wr_en <= {N_CLB{1'b0}};
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready_o = r_ready;
    assign bits_o      = r_bits;
    assign wr_en_o     = r_wr_en;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule
